// File: rtl/tm_gate_counter.sv
// Gated edge counter for the Tm window generator. It requests a window, counts sig_in rises while Tm is high,
// and holds the result under a valid/ack handshake. Define TM_GATE_SAT_EN to make the count saturate with an ovf flag.
module tm_gate_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         Tm,
  input  logic         sig_in,
  output logic         st,
  output logic [W-1:0] dout,
  output logic         dout_vld,
  input  logic         dout_ack,
  output logic         busy,
  output logic         ovf
);
  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_e;

  state_e       state_q, state_d;
  logic         s1_q, s2_q, s3_q, tm_d_q;
  logic [W-1:0] cnt_q, cnt_d, dout_q, dout_d;
  logic         st_q, st_d, vld_q, vld_d, busy_q, busy_d;
  logic         edge_c, cnt_en_c, start_c, latch_c, sat_c;

  assign edge_c   = s2_q & ~s3_q;
  assign cnt_en_c = ((state_q == ARM) || (state_q == GATE)) && Tm && edge_c;
  // Tm must be low before a new request so a window left over from reset is never joined mid-flight.
  assign start_c  = (state_q == IDLE) && run && !Tm;
  assign latch_c  = (state_q == GATE) && !Tm && tm_d_q;

`ifdef TM_GATE_SAT_EN
  logic ovf_int_q, ovf_q;

  assign sat_c = (cnt_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_int_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (start_c) begin
        ovf_int_q <= 1'b0;
      end else if (cnt_en_c && sat_c) begin
        ovf_int_q <= 1'b1;
      end
      if (latch_c) begin
        ovf_q <= ovf_int_q;
      end
    end
  end

  assign ovf = ovf_q;
`else
  assign sat_c = 1'b0;
  assign ovf   = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    st_d    = 1'b0;
    if (cnt_en_c && !sat_c) begin
      cnt_d = cnt_q + W'(1);
    end
    case (state_q)
      IDLE: begin
        if (start_c) begin
          st_d    = 1'b1;
          cnt_d   = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (Tm) begin
          state_d = GATE;
        end
      end
      GATE: begin
        if (latch_c) begin
          dout_d  = cnt_q;
          vld_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (dout_ack) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ARM) || (state_d == GATE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      tm_d_q  <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= '0;
      st_q    <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= sig_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      tm_d_q  <= Tm;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      st_q    <= st_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  assign st       = st_q;
  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_tm_gate_counter.sv
// Directed bench for tm_gate_counter: a W=16 instance for windows, handshake, stop and reset cases,
// and a W=4 instance for the overflow case. The bench models the Tm generator itself.
module tb_tm_gate_counter;
  localparam int unsigned W  = 16;
  localparam int unsigned W4 = 4;
  localparam int PRE  = 4;
  localparam int POST = 4;
`ifdef TM_GATE_SAT_EN
  localparam logic [15:0] EXP_DOUT4 = 16'd15;
  localparam logic        EXP_OVF4  = 1'b1;
`else
  localparam logic [15:0] EXP_DOUT4 = 16'd4;
  localparam logic        EXP_OVF4  = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, run, tm, sig_in, dout_ack;
  logic         st, dout_vld, busy, ovf;
  logic [W-1:0] dout;
  logic         run4, tm4, sig4, ack4;
  logic         st4, vld4, busy4, ovf4;
  logic [W4-1:0] dout4;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic        st;
    logic        vld;
    logic        busy;
    logic        ovf;
    logic [15:0] dout;
  } obs_t;

  typedef struct {
    int          tm_len;
    int          start;
    int          period;
    int          hold;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  tm_gate_counter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .Tm(tm), .sig_in(sig_in),
    .st(st), .dout(dout), .dout_vld(dout_vld), .dout_ack(dout_ack),
    .busy(busy), .ovf(ovf)
  );

  tm_gate_counter #(.W(W4)) u4 (
    .clk(clk), .rst_n(rst_n), .run(run4), .Tm(tm4), .sig_in(sig4),
    .st(st4), .dout(dout4), .dout_vld(vld4), .dout_ack(ack4),
    .busy(busy4), .ovf(ovf4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample(input bit w4);
    obs_t o;
    if (w4) begin
      o.st = st4; o.vld = vld4; o.busy = busy4; o.ovf = ovf4; o.dout = 16'(dout4);
    end else begin
      o.st = st; o.vld = dout_vld; o.busy = busy; o.ovf = ovf; o.dout = dout;
    end
    return o;
  endfunction

  task automatic drive(input bit w4, input logic tmv, input logic sv);
    if (w4) begin
      tm4 = tmv; sig4 = sv;
    end else begin
      tm = tmv; sig_in = sv;
    end
  endtask

  // Slot c is sampled on the c-th edge after st; a rise in slot c counts iff Tm is high in slot c+2.
  task automatic run_window(input bit w4, input int tm_len, input int start, input int period,
                            input int hold, input int drop_at, input logic [15:0] exp_dout,
                            input logic exp_ovf);
    obs_t o;
    int   len;
    int   bad;
    logic sv;
    logic tv;
    len = PRE + tm_len + POST;
    bad = 0;
    for (int c = 0; c < len; c++) begin
      sv = (c >= start) && (((c - start) % period) < (period / 2));
      tv = (c >= PRE) && (c < PRE + tm_len);
      if (c == drop_at) begin
        if (w4) run4 = 1'b0; else run = 1'b0;
      end
      drive(w4, tv, sv);
      step();
      o = sample(w4);
      if (c == 0) check("st_one_clk", o.st, 0);
      if (c == PRE + tm_len - 1) begin
        check("vld_before_fall", o.vld, 0);
        check("busy_in_gate", o.busy, 1);
      end
      if (c == PRE + tm_len) begin
        check("vld_after_fall", o.vld, 1);
        check("busy_after_fall", o.busy, 0);
      end
    end
    drive(w4, 1'b0, 1'b0);
    o = sample(w4);
    check("dout", o.dout, exp_dout);
    check("ovf", o.ovf, exp_ovf);
    for (int i = 0; i < hold; i++) begin
      step();
      o = sample(w4);
      if (o.dout !== exp_dout || o.vld !== 1'b1 || o.st !== 1'b0) bad++;
    end
    if (hold > 0) check("hold_stable", bad, 0);
  endtask

  task automatic ack_result(input bit w4, input logic [15:0] exp_dout, input logic exp_st);
    obs_t o;
    if (w4) ack4 = 1'b1; else dout_ack = 1'b1;
    step();
    o = sample(w4);
    check("vld_cleared", o.vld, 0);
    check("dout_kept", o.dout, exp_dout);
    if (w4) ack4 = 1'b0; else dout_ack = 1'b0;
    step();
    o = sample(w4);
    check("st_after_ack", o.st, exp_st);
  endtask

  task automatic wait_st(input bit w4);
    obs_t o;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      o = sample(w4);
      seen = o.st;
    end
    check("st_seen", seen, 1);
  endtask

  initial begin
    obs_t o;
    int   bad;
    rst_n = 1'b0; run = 1'b0; tm = 1'b0; sig_in = 1'b0; dout_ack = 1'b0;
    run4 = 1'b0; tm4 = 1'b0; sig4 = 1'b0; ack4 = 1'b0;
    //           tm_len start period hold  dout
    vecs[0] = '{256,   2,    8,     100,  16'd32};
    vecs[1] = '{10,    2,    10,    0,    16'd1};
    vecs[2] = '{10,    1,    10,    0,    16'd1};
    vecs[3] = '{20,    3,    4,     0,    16'd5};
    vecs[4] = '{7,     0,    2,     0,    16'd4};
    vecs[5] = '{1,     2,    3,     0,    16'd1};
    vecs[6] = '{5,     20,   4,     0,    16'd0};

    step();
    step();
    o = sample(0);
    check("rst_st", o.st, 0);
    check("rst_dout", o.dout, 0);
    check("rst_vld", o.vld, 0);
    check("rst_busy", o.busy, 0);
    check("rst_ovf", o.ovf, 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (3) begin
      step();
      if (st !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_without_run", bad, 0);
    run = 1'b1;
    step();
    check("st_first", st, 1);
    check("busy_arm", busy, 1);

    foreach (vecs[i]) begin
      run_window(0, vecs[i].tm_len, vecs[i].start, vecs[i].period, vecs[i].hold, -1,
                 vecs[i].exp_dout, 1'b0);
      ack_result(0, vecs[i].exp_dout, 1'b1);
    end

    // run dropped mid-GATE: result still delivered, no re-arm until run returns.
    run_window(0, 30, 2, 5, 0, 20, 16'd6, 1'b0);
    ack_result(0, 16'd6, 1'b0);
    bad = 0;
    repeat (8) begin
      step();
      if (st !== 1'b0) bad++;
    end
    check("no_st_when_stopped", bad, 0);
    run = 1'b1;
    step();
    check("st_rearm", st, 1);

    // Asynchronous reset in the middle of a gate window.
    for (int c = 0; c < 40; c++) begin
      tm = 1'b1;
      sig_in = c[0];
      step();
    end
    check("busy_mid_gate", busy, 1);
    check("dout_prev", dout, 6);
    #2 rst_n = 1'b0;
    #1;
    o = sample(0);
    check("async_rst_st", o.st, 0);
    check("async_rst_dout", o.dout, 0);
    check("async_rst_vld", o.vld, 0);
    check("async_rst_busy", o.busy, 0);
    check("async_rst_ovf", o.ovf, 0);
    tm = 1'b0;
    sig_in = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("st_after_reset", st, 1);

    // Stale window: Tm already high when leaving reset must not trigger st.
    rst_n = 1'b0;
    tm = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      step();
      if (st !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("stale_tm_no_st", bad, 0);
    tm = 1'b0;
    step();
    check("st_after_tm_low", st, 1);

    // 20 edges into a 4-bit counter.
    run4 = 1'b1;
    wait_st(1);
    run_window(1, 40, 2, 2, 0, 10, EXP_DOUT4, EXP_OVF4);
    ack_result(1, EXP_DOUT4, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
